// File: rtl/ssd_scan_driver_if.sv
// Bundle between the score/state logic and the seven-segment scan driver.
// Latency: none (wires only).
// Backpressure: none; the display is a free-running sink with no flow control.
// Ports: master drives digits_in/dp_in/blank_in/lz_suppress/brightness/load,
//        slave drives an/seg/dp/frame_start back out toward the board pins.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DUTY_BITS  = 3
);
  logic [4*NUM_DIGITS-1:0] digits_in;    // nibble per digit, [3:0] is digit 0
  logic [NUM_DIGITS-1:0]   dp_in;        // decimal point enable per digit
  logic [NUM_DIGITS-1:0]   blank_in;     // force digit dark
  logic                    lz_suppress;  // leading-zero suppression, live
  logic [DUTY_BITS-1:0]    brightness;   // PWM duty code, live
  logic                    load;         // one-cycle capture strobe
  logic [NUM_DIGITS-1:0]   an;           // anode enables
  logic [6:0]              seg;          // {a,b,c,d,e,f,g}
  logic                    dp;           // decimal point pin
  logic                    frame_start;  // pulse at start of digit-0 slot

  modport master (
    output digits_in, dp_in, blank_in, lz_suppress, brightness, load,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  digits_in, dp_in, blank_in, lz_suppress, brightness, load,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment scan driver with hex font, blank/dp, LZ suppression, PWM.
// Latency: an/seg/dp registered one clk after the scan state; loads appear at next frame boundary.
// Backpressure: none; load is always accepted, last load before a frame boundary wins.
// Ports: i_clk system clock; i_reset asynchronous active-low reset;
//        bus (slave modport) carries digit data/controls in and anode/segment pins out.
module ssd_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV_BITS  = 18,
  parameter int DUTY_BITS      = 3,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  ssd_scan_driver_if.slave    bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Inactive pin levels; XOR-ing a logical pattern with these applies polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [SCAN_DIV_BITS-1:0] r_presc;
  logic [IDX_W-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0]  r_sh_dig, r_dig;
  logic [NUM_DIGITS-1:0]    r_sh_dp, r_dp;
  logic [NUM_DIGITS-1:0]    r_sh_blank, r_blank;
  logic                     r_pending;
  logic                     r_frame_start;
  logic [NUM_DIGITS-1:0]    r_an;
  logic [6:0]               r_seg;
  logic                     r_dp_pin;

  logic                     w_slot_end;
  logic                     w_frame_end;
  logic [3:0]               w_nib;
  logic                     w_dp_sel;
  logic                     w_blank_sel;
  logic                     w_supp_sel;
  logic [NUM_DIGITS-1:0]    w_onehot;
  logic [NUM_DIGITS-1:0]    w_supp;
  logic                     w_run;
  logic                     w_duty;
  logic                     w_lit;

  function automatic logic [6:0] f_font(input logic [3:0] n);
    case (n)
      4'h0: f_font = 7'b1111110;
      4'h1: f_font = 7'b0110000;
      4'h2: f_font = 7'b1101101;
      4'h3: f_font = 7'b1111001;
      4'h4: f_font = 7'b0110011;
      4'h5: f_font = 7'b1011011;
      4'h6: f_font = 7'b1011111;
      4'h7: f_font = 7'b1110000;
      4'h8: f_font = 7'b1111111;
      4'h9: f_font = 7'b1111011;
      4'hA: f_font = 7'b1110111;
      4'hB: f_font = 7'b0011111;
      4'hC: f_font = 7'b1001110;
      4'hD: f_font = 7'b0111101;
      4'hE: f_font = 7'b1001111;
      default: f_font = 7'b1000111;
    endcase
  endfunction

  assign w_slot_end  = &r_presc;
  assign w_frame_end = w_slot_end && (r_idx == LAST_IDX);

  // Leading zeros: walk down from the top digit while nibbles stay zero.
  // Digit 0 is never part of the run.
  always_comb begin
    w_supp = '0;
    w_run  = bus.lz_suppress;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_run     = w_run && (r_dig[4*i +: 4] == 4'd0);
      w_supp[i] = w_run;
    end
  end

  // Select the committed data for the digit currently being scanned.
  always_comb begin
    w_nib       = 4'd0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b1;
    w_supp_sel  = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_dig[4*i +: 4];
        w_dp_sel    = r_dp[i];
        w_blank_sel = r_blank[i];
        w_supp_sel  = w_supp[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_duty = (r_presc[SCAN_DIV_BITS-1 -: DUTY_BITS] <= bus.brightness);
  // First clk of each slot stays dark so the previous digit's segments never
  // flash on the newly selected anode.
  assign w_lit  = !w_blank_sel && !w_supp_sel && w_duty && (r_presc != '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_sh_dig      <= '0;
      r_sh_dp       <= '0;
      r_sh_blank    <= '1;
      r_dig         <= '0;
      r_dp          <= '0;
      r_blank       <= '1;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_dp_pin      <= DP_OFF;
    end else begin
      r_presc <= r_presc + SCAN_DIV_BITS'(1);
      if (w_slot_end) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end

      // Commit reads the shadow as it was before this edge, so a load on the
      // boundary cycle itself stays pending for the following frame.
      if (w_frame_end && r_pending) begin
        r_dig   <= r_sh_dig;
        r_dp    <= r_sh_dp;
        r_blank <= r_sh_blank;
      end
      if (bus.load) begin
        r_sh_dig   <= bus.digits_in;
        r_sh_dp    <= bus.dp_in;
        r_sh_blank <= bus.blank_in;
        r_pending  <= 1'b1;
      end else if (w_frame_end) begin
        r_pending  <= 1'b0;
      end

      r_frame_start <= w_frame_end;

      r_an     <= w_lit ? (w_onehot ^ AN_OFF) : AN_OFF;
      r_seg    <= w_lit ? (f_font(w_nib) ^ SEG_OFF) : SEG_OFF;
      r_dp_pin <= w_lit ? (w_dp_sel ^ DP_OFF) : DP_OFF;
    end
  end

  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp_pin;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: 4 digits, 16-clk slots, 3-bit duty, active-low pins.
// Latency: outputs compared at negedge after every clk against a frame-level reference model.
// Backpressure: none; stimulus is driven at negedge and held across the next posedge.
module tb_ssd_scan_driver;
  localparam int ND  = 4;
  localparam int SDB = 4;
  localparam int DB  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssd_scan_driver_if #(.NUM_DIGITS(ND), .DUTY_BITS(DB)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV_BITS(SDB), .DUTY_BITS(DB),
    .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int          e;
    logic [15:0] d;
    logic [3:0]  dpv;
    logic [3:0]  bl;
  } ld_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dpv;
    logic [3:0]  bl;
    logic        lz;
    logic [3:0]  lit;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0} active-low pin codes
    logic [3:0]  dpo;    // dp pin level per digit
  } vec_t;

  ld_t  lds[$];
  vec_t tbl[7];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h7E; 4'h1: font = 7'h30; 4'h2: font = 7'h6D; 4'h3: font = 7'h79;
      4'h4: font = 7'h33; 4'h5: font = 7'h5B; 4'h6: font = 7'h5F; 4'h7: font = 7'h70;
      4'h8: font = 7'h7F; 4'h9: font = 7'h7B; 4'hA: font = 7'h77; 4'hB: font = 7'h1F;
      4'hC: font = 7'h4E; 4'hD: font = 7'h3D; 4'hE: font = 7'h4F; default: font = 7'h47;
    endcase
  endfunction

  // Expected {an, seg, dp, frame_start} seen after edge kk (edge 1 is the first after release).
  // Edge kk reflects the counter value kk-1; frames are 64 edges; the data shown is the
  // latest load strictly before the most recent frame-boundary edge.
  function automatic logic [12:0] model(input int kk, input logic lz, input logic [2:0] br);
    int          fb, p, idx;
    logic [15:0] d;
    logic [3:0]  dpv, bl;
    logic        lit, zero_above;
    d = 16'h0; dpv = 4'h0; bl = 4'hF;
    fb = ((kk - 1) / 64) * 64;
    if (fb > 0) begin
      for (int j = lds.size() - 1; j >= 0; j--) begin
        if (lds[j].e < fb) begin
          d = lds[j].d; dpv = lds[j].dpv; bl = lds[j].bl;
          break;
        end
      end
    end
    p   = (kk - 1) % 16;
    idx = ((kk - 1) / 16) % 4;
    zero_above = 1'b1;
    for (int j = idx; j < 4; j++) if (d[4*j +: 4] != 4'h0) zero_above = 1'b0;
    lit = !bl[idx] && !(lz && idx != 0 && zero_above) && ((p / 2) <= int'(br)) && (p != 0);
    model = {lit ? ~(4'b0001 << idx) : 4'hF,
             lit ? ~font(d[4*idx +: 4]) : 7'h7F,
             lit ? ~dpv[idx] : 1'b1,
             (kk % 64) == 0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // One clk: inputs already set; compare every output with the model at the following negedge.
  task automatic tick();
    ld_t        l;
    logic       lz;
    logic [2:0] br;
    @(posedge clk);
    k++;
    lz = bus.lz_suppress;
    br = bus.brightness;
    if (bus.load) begin
      l.e = k; l.d = bus.digits_in; l.dpv = bus.dp_in; l.bl = bus.blank_in;
      lds.push_back(l);
    end
    @(negedge clk);
    check("model", {19'd0, bus.an, bus.seg, bus.dp, bus.frame_start}, {19'd0, model(k, lz, br)});
    bus.load = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.frame_start && n < 200);
    if (!bus.frame_start) begin
      checks++;
      errors++;
      $display("FAIL wait_fs: no frame_start within 200 cycles, got 0 required 1");
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
    bus.digits_in = d; bus.dp_in = dpv; bus.blank_in = bl; bus.load = 1'b1;
    tick();
  endtask

  initial begin
    int          first, cnt, f0;
    logic [27:0] sv;
    logic [3:0]  ea;

    tbl[0] = '{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF};
    tbl[1] = '{16'h0007, 4'h0, 4'h0, 1'b1, 4'h1, {7'h7F, 7'h7F, 7'h7F, 7'h0F}, 4'hF};
    tbl[2] = '{16'h0007, 4'h0, 4'h0, 1'b0, 4'hF, {7'h01, 7'h01, 7'h01, 7'h0F}, 4'hF};
    tbl[3] = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'h1, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF};
    tbl[4] = '{16'hF0E8, 4'h5, 4'h2, 1'b1, 4'hD, {7'h38, 7'h01, 7'h7F, 7'h00}, 4'hA};
    tbl[5] = '{16'h0090, 4'hF, 4'h0, 1'b1, 4'h3, {7'h7F, 7'h7F, 7'h04, 7'h01}, 4'hC};
    tbl[6] = '{16'h6BC5, 4'h0, 4'h0, 1'b0, 4'hF, {7'h20, 7'h60, 7'h31, 7'h24}, 4'hF};

    bus.digits_in = '0; bus.dp_in = '0; bus.blank_in = '0;
    bus.lz_suppress = 1'b0; bus.brightness = 3'd7; bus.load = 1'b0;

    // Reset state.
    @(negedge clk); @(negedge clk);
    check("rst_an", {28'd0, bus.an}, 32'hF);
    check("rst_seg", {25'd0, bus.seg}, 32'h7F);
    check("rst_dp", {31'd0, bus.dp}, 32'h1);
    check("rst_fs", {31'd0, bus.frame_start}, 32'h0);

    rst_n = 1'b1;
    k = 0;
    lds.delete();

    // First frame_start 64 clk after release; display stays dark meanwhile.
    first = -1;
    for (int i = 0; i < 100 && first < 0; i++) begin
      tick();
      if (bus.frame_start) first = k;
    end
    check("first_fs", first, 64);

    // Table: load, wait for commit, then sample each digit at slot offset 1.
    for (int t = 0; t < 7; t++) begin
      bus.lz_suppress = tbl[t].lz;
      do_load(tbl[t].d, tbl[t].dpv, tbl[t].bl);
      wait_fs();
      tick();
      check($sformatf("guard%0d", t), {28'd0, bus.an}, 32'hF);
      tick();
      sv = tbl[t].segs;
      for (int d = 0; d < 4; d++) begin
        ea = tbl[t].lit[d] ? ~(4'b0001 << d) : 4'hF;
        check($sformatf("tbl%0d_an%0d", t, d), {28'd0, bus.an}, {28'd0, ea});
        check($sformatf("tbl%0d_seg%0d", t, d), {25'd0, bus.seg}, {25'd0, sv[7*d +: 7]});
        check($sformatf("tbl%0d_dp%0d", t, d), {31'd0, bus.dp}, {31'd0, tbl[t].dpo[d]});
        if (d < 3) ticks(16);
      end
    end

    // Duty: lit clocks per full frame = 4 digits * (2*brightness + 1).
    for (int b = 0; b < 8; b += 3) begin
      bus.brightness = 3'(b);
      wait_fs();
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
        tick();
        if (bus.an != 4'hF) cnt++;
      end
      check($sformatf("duty%0d", b), cnt, 4 * (2 * b + 1));
    end
    bus.brightness = 3'd7;

    // Two loads mid-frame: nothing changes until the boundary, then the last wins.
    wait_fs();
    f0 = k;
    ticks(4);
    do_load(16'hAAAA, 4'h0, 4'h0);
    ticks(2);
    do_load(16'h5555, 4'h0, 4'h0);
    while (k < f0 + 18) tick();
    check("no_tear", {25'd0, bus.seg}, 32'h31);
    wait_fs();
    ticks(2);
    check("last_wins", {25'd0, bus.seg}, 32'h24);

    // Load exactly on the boundary edge appears one frame later.
    while (((k + 1) % 64) != 0) tick();
    do_load(16'h1234, 4'h0, 4'h0);
    check("bnd_fs", {31'd0, bus.frame_start}, 32'h1);
    ticks(2);
    check("bnd_old", {25'd0, bus.seg}, 32'h24);
    wait_fs();
    ticks(2);
    check("bnd_new", {25'd0, bus.seg}, 32'h4C);

    // Asynchronous reset while digit 2 is lit.
    cnt = 0;
    while (bus.an != 4'b1011 && cnt < 200) begin
      tick();
      cnt++;
    end
    check("arst_seen_d2", {28'd0, bus.an}, 32'hB);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", {28'd0, bus.an}, 32'hF);
    check("arst_seg", {25'd0, bus.seg}, 32'h7F);
    check("arst_dp", {31'd0, bus.dp}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    lds.delete();
    cnt = 0;
    for (int i = 0; i < 140; i++) begin
      tick();
      if (bus.an != 4'hF) cnt++;
    end
    check("arst_blank", cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) bus.lz_suppress = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) bus.brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 6) begin
        for (int j = 0; j < 4; j++)
          bus.digits_in[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        bus.dp_in    = 4'($urandom_range(0, 15));
        bus.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        bus.load     = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
